sample_recorder: RTL and testbench

Captures the 16-bit sample stream produced by the music player (sample plus one-cycle valid strobe) into an on-chip sample buffer. It then replays that buffer back toward the codec path, one word per codec sample request. It sits on the opposite side of the sample interface from the note/keyboard sources: it consumes a sample_out/new_sample_generated pair while recording, and produces a sample/ready pair into the codec conditioner's latch interface while replaying.

---
 rtl/sample_recorder.sv | 153 +++++++++++++++
 tb/tb_sample_recorder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sample_recorder.sv
// sample_recorder: captures a strobed 16-bit sample stream into an on-chip
// buffer, then replays it one word per codec request, optionally looping.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | buffer holds length samples; waiting for record/replay
// RECORD  | each valid sample is appended until stop or buffer full
// REPLAY  | each codec request reads the next word; wraps when looping
module sample_recorder #(
  parameter int   ADDR_WIDTH   = 10,
  parameter logic LOOP_DEFAULT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  record_button,
  input  logic                  replay_button,
  input  logic                  loop_toggle,
  input  logic [15:0]           sample_in,
  input  logic                  sample_in_valid,
  input  logic                  generate_next_sample,
  output logic [15:0]           sample_out,
  output logic                  sample_out_ready,
  output logic [1:0]            state,
  output logic [ADDR_WIDTH:0]   length,
  output logic                  full,
  output logic                  looping
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_REPLAY = 2'b10
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_d, rd_ptr_d;
  logic [ADDR_WIDTH:0]   length_q;
  logic                  looping_q;
  logic                  ready_q;
  logic                  last_q;      // final non-looping read is in flight
  logic [15:0]           sample_out_q;
  logic [15:0]           mem_q [DEPTH];

  logic                  wr_en_d, rd_en_d, wr_last_d, rd_last_d;

  // Accepted write/read strobes and pointer arithmetic.
  always_comb begin
    wr_en_d   = (state_q == ST_RECORD) && sample_in_valid && !record_button;
    rd_en_d   = (state_q == ST_REPLAY) && generate_next_sample &&
                !replay_button && !last_q;
    wr_last_d = (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1));
    rd_last_d = ({1'b0, rd_ptr_q} == (length_q - (ADDR_WIDTH + 1)'(1)));
    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
  end

  // Sample buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  // Registered read port doubles as the held output word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out_q <= 16'h0000;
    end else if (rd_en_d) begin
      sample_out_q <= mem_q[rd_ptr_q];
    end
  end

  // Control FSM with pointers, length, loop bit and ready strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      length_q  <= '0;
      looping_q <= LOOP_DEFAULT;
      ready_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      ready_q <= rd_en_d;
      if (loop_toggle) begin
        looping_q <= ~looping_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (record_button) begin
            state_q  <= ST_RECORD;
            wr_ptr_q <= '0;
            length_q <= '0;
          end else if (replay_button && (length_q != '0)) begin
            state_q  <= ST_REPLAY;
            rd_ptr_q <= '0;
            last_q   <= 1'b0;
          end
        end
        ST_RECORD: begin
          if (record_button) begin
            // Stop wins over a coincident sample, which is dropped.
            state_q  <= ST_IDLE;
            length_q <= {1'b0, wr_ptr_q};
          end else if (sample_in_valid) begin
            wr_ptr_q <= wr_ptr_d;
            length_q <= length_q + (ADDR_WIDTH + 1)'(1);
            if (wr_last_d) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_REPLAY: begin
          if (replay_button) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b0;
          end else if (last_q) begin
            // The final ready pulse is on the output this cycle.
            state_q <= ST_IDLE;
            last_q  <= 1'b0;
          end else if (rd_en_d) begin
            if (rd_last_d) begin
              if (looping_q) begin
                rd_ptr_q <= '0;
              end else begin
                rd_ptr_q <= rd_ptr_d;
                last_q   <= 1'b1;
              end
            end else begin
              rd_ptr_q <= rd_ptr_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_out       = sample_out_q;
  assign sample_out_ready = ready_q;
  assign state            = state_q;
  assign length           = length_q;
  // length never exceeds DEPTH, so its MSB alone marks a full buffer.
  assign full             = length_q[ADDR_WIDTH];
  assign looping          = looping_q;

endmodule

// File: tb/tb_sample_recorder.sv
// Directed bench for sample_recorder with an 8-deep buffer.
module tb_sample_recorder;

  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        record_button = 1'b0;
  logic        replay_button = 1'b0;
  logic        loop_toggle = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        sample_in_valid = 1'b0;
  logic        generate_next_sample = 1'b0;
  logic [15:0] sample_out;
  logic        sample_out_ready;
  logic [1:0]  state;
  logic [AW:0] length;
  logic        full;
  logic        looping;

  int n_checks = 0;
  int n_errors = 0;

  sample_recorder #(.ADDR_WIDTH(AW), .LOOP_DEFAULT(1'b0)) dut (
    .clk                  (clk),
    .reset                (reset),
    .record_button        (record_button),
    .replay_button        (replay_button),
    .loop_toggle          (loop_toggle),
    .sample_in            (sample_in),
    .sample_in_valid      (sample_in_valid),
    .generate_next_sample (generate_next_sample),
    .sample_out           (sample_out),
    .sample_out_ready     (sample_out_ready),
    .state                (state),
    .length               (length),
    .full                 (full),
    .looping              (looping)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_record();
    record_button = 1'b1; tick(); record_button = 1'b0;
  endtask

  task automatic press_replay();
    replay_button = 1'b1; tick(); replay_button = 1'b0;
  endtask

  task automatic press_loop();
    loop_toggle = 1'b1; tick(); loop_toggle = 1'b0;
  endtask

  task automatic feed(input logic [15:0] val);
    sample_in = val; sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0;
  endtask

  // One codec request followed by an idle cycle.
  task automatic req(input string tag, input logic exp_rdy, input logic [15:0] exp_val);
    check({tag, "_pre_rdy"}, 32'(sample_out_ready), 32'd0);
    generate_next_sample = 1'b1; tick(); generate_next_sample = 1'b0;
    check({tag, "_rdy"}, 32'(sample_out_ready), 32'(exp_rdy));
    if (exp_rdy) check({tag, "_val"}, 32'(sample_out), 32'(exp_val));
    tick();
    check({tag, "_rdy_gone"}, 32'(sample_out_ready), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_length", 32'(length), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_out", 32'(sample_out), 32'd0);
    check("rst_rdy", 32'(sample_out_ready), 32'd0);
    check("rst_loop", 32'(looping), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Test 1: record five samples and stop
    press_record();
    check("t1_state_rec", 32'(state), 32'd1);
    for (int i = 1; i <= 5; i++) feed({i[7:0], i[7:0]});
    check("t1_len_live", 32'(length), 32'd5);
    press_record();
    check("t1_state", 32'(state), 32'd0);
    check("t1_length", 32'(length), 32'd5);
    check("t1_full", 32'(full), 32'd0);

    // Test 2: non-looping replay, 7 requests
    press_replay();
    check("t2_state_rep", 32'(state), 32'd2);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b;
      b = 8'(k + 1);
      req($sformatf("t2_req%0d", k + 1), 1'b1, {b, b});
    end
    check("t2_state_end", 32'(state), 32'd0);
    req("t2_req6", 1'b0, 16'h0000);
    req("t2_req7", 1'b0, 16'h0000);
    check("t2_hold_out", 32'(sample_out), 32'h0505);

    // Test 4: looping replay of the 5-sample buffer
    press_loop();
    check("t4_loop_on", 32'(looping), 32'd1);
    press_replay();
    for (int k = 0; k < 12; k++) begin
      logic [7:0] b;
      b = 8'((k % 5) + 1);
      req($sformatf("t4_req%0d", k + 1), 1'b1, {b, b});
    end
    check("t4_state_stays", 32'(state), 32'd2);
    press_replay();
    check("t4_stop", 32'(state), 32'd0);
    press_loop();
    check("t4_loop_off", 32'(looping), 32'd0);

    // Test 5: stop coincident with a valid sample drops that sample
    press_record();
    feed(16'h0A0A); feed(16'h0B0B); feed(16'h0C0C);
    record_button = 1'b1; sample_in = 16'hBEEF; sample_in_valid = 1'b1;
    tick();
    record_button = 1'b0; sample_in_valid = 1'b0;
    check("t5_state", 32'(state), 32'd0);
    check("t5_length", 32'(length), 32'd3);
    press_replay();
    req("t5_req1", 1'b1, 16'h0A0A);
    req("t5_req2", 1'b1, 16'h0B0B);
    req("t5_req3", 1'b1, 16'h0C0C);
    req("t5_req4", 1'b0, 16'h0000);
    check("t5_no_beef", 32'(sample_out), 32'h0C0C);
    record_button = 1'b1; replay_button = 1'b1;
    tick();
    record_button = 1'b0; replay_button = 1'b0;
    check("t5_rec_wins", 32'(state), 32'd1);

    // Test 3: overfill auto-stops at 8 samples (recording already active)
    for (int i = 1; i <= 10; i++) begin
      feed(16'(i));
      if (i == 8) check("t3_autostop", 32'(state), 32'd0);
    end
    check("t3_state", 32'(state), 32'd0);
    check("t3_length", 32'(length), 32'd8);
    check("t3_full", 32'(full), 32'd1);
    press_replay();
    for (int k = 1; k <= 8; k++) req($sformatf("t3_req%0d", k), 1'b1, 16'(k));
    check("t3_state_end", 32'(state), 32'd0);
    req("t3_req9", 1'b0, 16'h0000);

    // Test 6: asynchronous reset during replay
    press_replay();
    req("t6_req1", 1'b1, 16'h0001);
    req("t6_req2", 1'b1, 16'h0002);
    generate_next_sample = 1'b1; tick(); generate_next_sample = 1'b0;
    check("t6_inflight", 32'(sample_out_ready), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_state", 32'(state), 32'd0);
    check("t6_length", 32'(length), 32'd0);
    check("t6_out", 32'(sample_out), 32'd0);
    check("t6_rdy", 32'(sample_out_ready), 32'd0);
    check("t6_full", 32'(full), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    press_replay();
    check("t6_replay_ignored", 32'(state), 32'd0);
    req("t6_req_after", 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
